// File: rtl/perf_pkg.sv
// Shared types and widths for the performance-counter bank and its controller.
package perf_pkg;

    localparam int PERF_CNT_W = 64;
    localparam int PERF_RD_W  = 32;

    typedef logic [PERF_CNT_W-1:0] counter_t;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_STOP  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_READ  = 2'd3
    } ctrl_op_t;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_CLEAR = 2'd1,
        C_WAIT  = 2'd2,
        C_RESP  = 2'd3
    } ctrl_state_t;

    // Select the low or high 32-bit half of a 64-bit counter value.
    function automatic logic [PERF_RD_W-1:0] rd_word(input counter_t value, input logic hi);
        return hi ? value[PERF_CNT_W-1:PERF_RD_W] : value[PERF_RD_W-1:0];
    endfunction

endpackage

// File: rtl/perf_window_timer.sv
// Measurement-window down-counter; only built when PERF_CTRL_WINDOW_EN is defined.
`ifdef PERF_CTRL_WINDOW_EN
module perf_window_timer #(
    parameter int WIN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIN_W-1:0] len,
    input  logic             en,
    output logic             expire
);

    logic [WIN_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= len;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - WIN_W'(1);
        end
    end

    // A reload in the same cycle takes priority, so no pulse is produced then.
    assign expire = en & ~load & (cnt_reg == WIN_W'(1));

endmodule
`endif

// File: rtl/perf_counter_ctrl.sv
// Command-port controller for a bank of perf counters: start/stop/clear triggers and 32-bit indexed read-out.
// Optional measurement window enabled by defining PERF_CTRL_WINDOW_EN.
module perf_counter_ctrl
    import perf_pkg::*;
#(
    parameter int NUM_CNT = 8,
    parameter int IDX_W   = $clog2(NUM_CNT),
    parameter int WIN_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  ctrl_op_t                      req_op,
    input  logic [IDX_W-1:0]              req_idx,
    input  logic                          req_hi,
    output logic                          resp_valid,
    output logic [PERF_RD_W-1:0]          resp_data,
    input  logic [NUM_CNT*PERF_CNT_W-1:0] cnt_values,
    output logic                          toggle_trigger,
    output logic                          clear_trigger,
`ifdef PERF_CTRL_WINDOW_EN
    input  logic [WIN_W-1:0]              win_len,
    output logic                          window_done,
`endif
    output logic                          busy
);

    ctrl_state_t            state_reg, state_next;
    logic                   running_reg, running_next;
    logic                   armed_reg, armed_next;
    logic                   was_run_reg, was_run_next;
    logic [PERF_RD_W-1:0]   snap_hi_reg, snap_hi_next;
    logic [IDX_W-1:0]       snap_idx_reg, snap_idx_next;
    logic [PERF_RD_W-1:0]   rdata_reg, rdata_next;

    counter_t               cnt_arr [NUM_CNT];
    counter_t               sel_cnt;
    logic                   idx_hit;
    logic                   accept;
    logic                   win_expire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_unpack
            assign cnt_arr[gi] = cnt_values[gi*PERF_CNT_W +: PERF_CNT_W];
        end
    endgenerate

    // Out-of-range indices match nothing and read as zero.
    always_comb begin
        sel_cnt = '0;
        idx_hit = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (req_idx == IDX_W'(i)) begin
                sel_cnt = cnt_arr[i];
                idx_hit = 1'b1;
            end
        end
    end

    assign accept = req_valid & (state_reg == C_IDLE);

`ifdef PERF_CTRL_WINDOW_EN
    perf_window_timer #(
        .WIN_W (WIN_W)
    ) u_window_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (accept && (req_op == OP_START)),
        .len    (win_len),
        .en     (running_reg),
        .expire (win_expire)
    );
    assign window_done = win_expire;
`else
    logic unused_win;
    assign win_expire = 1'b0;
    assign unused_win = (WIN_W > 0);
`endif

    always_comb begin
        state_next    = state_reg;
        running_next  = running_reg;
        armed_next    = armed_reg;
        was_run_next  = was_run_reg;
        snap_hi_next  = snap_hi_reg;
        snap_idx_next = snap_idx_reg;
        rdata_next    = rdata_reg;
        case (state_reg)
            C_IDLE: begin
                if (req_valid) begin
                    state_next = C_RESP;
                    rdata_next = '0;
                    case (req_op)
                        OP_START: begin
                            running_next = 1'b1;
                            armed_next   = 1'b1;
                        end
                        OP_STOP: begin
                            running_next = 1'b0;
                        end
                        OP_CLEAR: begin
                            // Unarmed counters already hold zero, so skip the clear pulse.
                            if (armed_reg) begin
                                was_run_next = running_reg & ~win_expire;
                                running_next = 1'b0;
                                state_next   = C_CLEAR;
                            end
                        end
                        OP_READ: begin
                            if (!req_hi) begin
                                rdata_next = rd_word(sel_cnt, 1'b0);
                                if (idx_hit) begin
                                    snap_hi_next  = rd_word(sel_cnt, 1'b1);
                                    snap_idx_next = req_idx;
                                end
                            end else if (idx_hit && (req_idx == snap_idx_reg)) begin
                                rdata_next = snap_hi_reg;
                            end else begin
                                rdata_next = rd_word(sel_cnt, 1'b1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            C_CLEAR: state_next = C_WAIT;
            C_WAIT: begin
                state_next   = C_RESP;
                running_next = was_run_reg;
                armed_next   = was_run_reg;
            end
            C_RESP: state_next = C_IDLE;
            default: state_next = C_IDLE;
        endcase
        if (win_expire) begin
            running_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= C_IDLE;
            running_reg  <= 1'b0;
            armed_reg    <= 1'b0;
            was_run_reg  <= 1'b0;
            snap_hi_reg  <= '0;
            snap_idx_reg <= '0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            running_reg  <= running_next;
            armed_reg    <= armed_next;
            was_run_reg  <= was_run_next;
            snap_hi_reg  <= snap_hi_next;
            snap_idx_reg <= snap_idx_next;
            rdata_reg    <= rdata_next;
        end
    end

    assign req_ready      = (state_reg == C_IDLE);
    assign busy           = ~req_ready;
    assign resp_valid     = (state_reg == C_RESP);
    assign resp_data      = resp_valid ? rdata_reg : '0;
    assign toggle_trigger = running_reg;
    assign clear_trigger  = (state_reg == C_CLEAR);

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Directed bench for perf_counter_ctrl with a behavioural counter bank and a response scoreboard.
module tb_perf_counter_ctrl;
    import perf_pkg::*;

    localparam int NUM_CNT = 6;
    localparam int IDX_W   = 3;
    localparam int WIN_W   = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     req_valid;
    logic                     req_ready;
    ctrl_op_t                 req_op;
    logic [IDX_W-1:0]         req_idx;
    logic                     req_hi;
    logic                     resp_valid;
    logic [31:0]              resp_data;
    logic [NUM_CNT*64-1:0]    cnt_values;
    logic                     toggle_trigger;
    logic                     clear_trigger;
    logic                     busy;
`ifdef PERF_CTRL_WINDOW_EN
    logic [WIN_W-1:0]         win_len;
    logic                     window_done;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int tog_cnt = 0;
    int clr_cnt = 0;
    int wd_cnt  = 0;

    perf_counter_ctrl #(
        .NUM_CNT (NUM_CNT),
        .IDX_W   (IDX_W),
        .WIN_W   (WIN_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_idx        (req_idx),
        .req_hi         (req_hi),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .cnt_values     (cnt_values),
        .toggle_trigger (toggle_trigger),
        .clear_trigger  (clear_trigger),
`ifdef PERF_CTRL_WINDOW_EN
        .win_len        (win_len),
        .window_done    (window_done),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Behavioural counter bank driven by the controller's trigger levels.
    logic [63:0]        cnt_m [NUM_CNT];
    logic [NUM_CNT-1:0] inc;
    logic               pre_en;
    int                 pre_idx;
    logic [63:0]        pre_val;

    always @(posedge clk) begin
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rst || clear_trigger)
                cnt_m[i] <= 64'd0;
            else if (pre_en && pre_idx == i)
                cnt_m[i] <= pre_val;
            else if (toggle_trigger && inc[i])
                cnt_m[i] <= cnt_m[i] + 64'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_pack
            assign cnt_values[gi*64 +: 64] = cnt_m[gi];
        end
    endgenerate

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (toggle_trigger === 1'b1) tog_cnt++;
        if (clear_trigger === 1'b1) clr_cnt++;
`ifdef PERF_CTRL_WINDOW_EN
        if (window_done === 1'b1) wd_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          when;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", resp_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_data"}, resp_data, e.data);
                chk({e.tag, "_cycle"}, cyc, e.when);
                $display("resp %s data=%08h cycle=%0d", e.tag, resp_data, cyc);
            end
        end
    end

    task automatic send(input string tag, input ctrl_op_t op, input int idx, input logic hi,
                        input logic [31:0] exp, input int lat, output int t_acc);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk({tag, "_ready_timeout"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_op    = op;
        req_idx   = IDX_W'(idx);
        req_hi    = hi;
        t_acc     = cyc;
        sb.push_back('{data: exp, when: cyc + lat, tag: tag});
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, "_ready_drop"}, req_ready, 1'b0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || req_ready !== 1'b1) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk({tag, "_drain_timeout"}, sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t_start, t_stop, base, tb0, wb0;
        rst = 1'b1; req_valid = 1'b0; req_op = OP_START; req_idx = '0; req_hi = 1'b0;
        inc = '0; pre_en = 1'b0; pre_idx = 0; pre_val = '0;
`ifdef PERF_CTRL_WINDOW_EN
        win_len = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_toggle", toggle_trigger, 1'b0);
        chk("rst_clear", clear_trigger, 1'b0);
`ifdef PERF_CTRL_WINDOW_EN
        chk("rst_window_done", window_done, 1'b0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // CLEAR with nothing armed: immediate response, no clear pulse.
        base = clr_cnt;
        send("clr_idle", OP_CLEAR, 0, 1'b0, 32'd0, 1, t);
        drain("clr_idle");
        chk("clr_idle_pulses", clr_cnt - base, 0);

        // START, count 10, STOP, read back.
        tb0 = tog_cnt;
        send("start1", OP_START, 0, 1'b0, 32'd0, 1, t_start);
        chk("start1_toggle", toggle_trigger, 1'b1);
        inc[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1 inc[0] = 1'b0;
        send("stop1", OP_STOP, 0, 1'b0, 32'd0, 1, t_stop);
        chk("stop1_toggle", toggle_trigger, 1'b0);
        chk("start_stop_span", tog_cnt - tb0, t_stop - t_start);
        send("rd_c0_lo", OP_READ, 0, 1'b0, 32'd10, 1, t);
        send("rd_c0_hi", OP_READ, 0, 1'b1, 32'd0, 1, t);

        // CLEAR while running with counter 1 at 25.
        send("start2", OP_START, 0, 1'b0, 32'd0, 1, t);
        inc[1] = 1'b1;
        repeat (25) @(posedge clk);
        #1 inc[1] = 1'b0;
        send("rd_c1_lo", OP_READ, 1, 1'b0, 32'd25, 1, t);
        drain("rd_c1_lo");
        base = clr_cnt;
        send("clr_run", OP_CLEAR, 0, 1'b0, 32'd0, 3, t);
        chk("clr_t1_clear", clear_trigger, 1'b1);
        chk("clr_t1_toggle", toggle_trigger, 1'b0);
        @(posedge clk); #1;
        chk("clr_t2_clear", clear_trigger, 1'b0);
        chk("clr_t2_toggle", toggle_trigger, 1'b0);
        chk("clr_t2_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        chk("clr_t3_toggle", toggle_trigger, 1'b1);
        chk("clr_t3_cnt1", cnt_m[1], 64'd0);
        inc[1] = 1'b1;
        @(posedge clk); #1;
        inc[1] = 1'b0;
        chk("clr_t4_cnt1", cnt_m[1], 64'd1);
        chk("clr_run_pulses", clr_cnt - base, 1);
        send("rd_c1_after", OP_READ, 1, 1'b0, 32'd1, 1, t);
        send("stop2", OP_STOP, 0, 1'b0, 32'd0, 1, t);

        // Snapshot of the high word across a carry, out-of-range reads.
        pre_en = 1'b1; pre_idx = 2; pre_val = 64'h0000_0001_FFFF_FFFF;
        @(posedge clk); #1;
        pre_idx = 3; pre_val = 64'h0000_00AB_0000_0012;
        @(posedge clk); #1;
        pre_en = 1'b0;
        send("start3", OP_START, 0, 1'b0, 32'd0, 1, t);
        send("rd_c2_lo", OP_READ, 2, 1'b0, 32'hFFFF_FFFF, 1, t);
        inc[2] = 1'b1;
        @(posedge clk); #1;
        inc[2] = 1'b0;
        chk("c2_carried", cnt_m[2], 64'h0000_0002_0000_0000);
        send("rd_c2_hi", OP_READ, 2, 1'b1, 32'h0000_0001, 1, t);
        send("rd_oor_lo", OP_READ, NUM_CNT, 1'b0, 32'd0, 1, t);
        send("rd_c2_hi_again", OP_READ, 2, 1'b1, 32'h0000_0001, 1, t);
        send("rd_c3_hi_live", OP_READ, 3, 1'b1, 32'h0000_00AB, 1, t);
        send("rd_oor_hi", OP_READ, 7, 1'b1, 32'd0, 1, t);
        send("stop3", OP_STOP, 0, 1'b0, 32'd0, 1, t);
        drain("stop3");

`ifdef PERF_CTRL_WINDOW_EN
        // Window of 5 cycles with counter 4 incrementing throughout.
        win_len = 32'd5;
        inc[4] = 1'b1;
        tb0 = tog_cnt;
        wb0 = wd_cnt;
        send("start_win", OP_START, 0, 1'b0, 32'd0, 1, t);
        repeat (12) @(posedge clk);
        #1;
        chk("win_toggle_cycles", tog_cnt - tb0, 5);
        chk("win_done_pulses", wd_cnt - wb0, 1);
        chk("win_toggle_end", toggle_trigger, 1'b0);
        inc[4] = 1'b0;
        win_len = '0;
        send("rd_c4_win", OP_READ, 4, 1'b0, 32'd5, 1, t);
        drain("rd_c4_win");
`else
        wb0 = 0;
`endif

        // Reset in the middle of an armed CLEAR.
        send("start4", OP_START, 0, 1'b0, 32'd0, 1, t);
        send("clr_rst", OP_CLEAR, 0, 1'b0, 32'd0, 3, t);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        chk("midclr_rst_ready", req_ready, 1'b1);
        chk("midclr_rst_toggle", toggle_trigger, 1'b0);
        chk("midclr_rst_clear", clear_trigger, 1'b0);
        chk("midclr_rst_resp", resp_valid, 1'b0);
        base = clr_cnt;
        send("clr_after_rst", OP_CLEAR, 0, 1'b0, 32'd0, 1, t);
        drain("clr_after_rst");
        chk("clr_after_rst_pulses", clr_cnt - base, 0);
        pre_en = 1'b1; pre_idx = 0; pre_val = 64'h0000_0005_0000_0000;
        @(posedge clk); #1;
        pre_en = 1'b0;
        send("rd_snap_rst", OP_READ, 0, 1'b1, 32'd0, 1, t);
        drain("rd_snap_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
